// File: rtl/kernel_scheduler.sv
// Round-robin front end that shares one pipelined kernel between NUM_REQ requesters and reorders nothing.
// Latency: an operand granted in cycle T shows its result at the head in cycle T+LAT+1 (FIFO empty).
// Backpressure: grants stop once in-flight plus buffered results reach DEPTH, so the FIFO never overflows.
// Optional build: define KSCHED_PERF_EN to add the perf_issue_cnt_o grant counter port.
module kernel_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int LAT     = 5,
    parameter int DEPTH   = 8,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [NUM_REQ*8-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]     req_sign_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic [7:0]             k_data_o,
    output logic                   k_sign_o,
    input  logic [9:0]             k_result_i,
    output logic                   res_valid_o,
    input  logic                   res_ready_i,
    output logic [9:0]             res_data_o,
    output logic [ID_W-1:0]        res_id_o
`ifdef KSCHED_PERF_EN
    ,
    output logic [15:0]            perf_issue_cnt_o
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [9:0]      dat;
    } res_t;

    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic             grant_vld;
    logic [ID_W-1:0]  grant_id;
    logic             credit_ok;
    logic [CNT_W:0]   occupancy;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    res_t             mem_q [DEPTH];
    res_t             head;
    logic [LAT-1:0]   tag_vld_q;
    logic [ID_W-1:0]  tag_id_q [LAT];
    logic             push;
    logic             pop;

    // Every accepted operand owns a FIFO slot from grant until it is popped.
    assign occupancy = {1'b0, inflight_q} + {1'b0, count_q};
    assign credit_ok = occupancy < (CNT_W+1)'(DEPTH);

    // Round-robin search: scan offsets high to low so the lowest offset from rr_ptr wins.
    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (req_valid_i[idx]) begin
                grant_vld = 1'b1;
                grant_id  = ID_W'(idx);
            end
        end
        if (rst_i || !credit_ok) begin
            grant_vld = 1'b0;
        end
    end

    // One-hot grant back to the requesters.
    always_comb begin
        req_ready_o = '0;
        if (grant_vld) begin
            req_ready_o[grant_id] = 1'b1;
        end
    end

    // Kernel operand mux; idle cycles drive zero.
    always_comb begin
        k_data_o = '0;
        k_sign_o = 1'b0;
        if (grant_vld) begin
            k_data_o = req_data_i[int'(grant_id)*8 +: 8];
            k_sign_o = req_sign_i[grant_id];
        end
    end

    // Pointer moves just past the granted requester, holds otherwise.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_vld) begin
            rr_ptr_d = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
        end
    end

    assign push = tag_vld_q[LAT-1];
    assign pop  = (count_q != '0) && res_ready_i;

    // In-flight and FIFO occupancy bookkeeping; simultaneous inc/dec cancel.
    always_comb begin
        inflight_d = inflight_q;
        if (grant_vld && !push) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!grant_vld && push) begin
            inflight_d = inflight_q - 1'b1;
        end
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Control state; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q   <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Tag valid bits follow the kernel pipeline; clearing them drops stale kernel outputs after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tag_vld_q <= '0;
        end else begin
            tag_vld_q[0] <= grant_vld;
            for (int i = 1; i < LAT; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
            end
        end
    end

    // Tag ids are only meaningful alongside a valid bit, so they need no reset.
    always_ff @(posedge clk_i) begin
        tag_id_q[0] <= grant_id;
        for (int i = 1; i < LAT; i++) begin
            tag_id_q[i] <= tag_id_q[i-1];
        end
    end

    // Result storage, written when the last tag stage lines up with the kernel output.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {tag_id_q[LAT-1], k_result_i};
        end
    end

    assign head        = mem_q[rd_ptr_q];
    assign res_valid_o = (count_q != '0) && !rst_i;
    assign res_data_o  = head.dat;
    assign res_id_o    = head.id;

`ifdef KSCHED_PERF_EN
    logic [15:0] perf_cnt_q;

    // Grant counter, saturating at all-ones.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_cnt_q <= '0;
        end else if (grant_vld && (perf_cnt_q != 16'hFFFF)) begin
            perf_cnt_q <= perf_cnt_q + 1'b1;
        end
    end

    assign perf_issue_cnt_o = perf_cnt_q;
`endif

endmodule

// File: doc/kernel_scheduler.md
KERNEL_SCHEDULER -- requirements
Module: kernel_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, is the number of requesters sharing the computing kernel (2..8).
REQ-002 Parameter LAT, default 5, is the kernel latency in clk cycles from input to registered output.
REQ-003 Parameter DEPTH, default 8, is the number of result FIFO entries (power of two, at least LAT+1).
REQ-004 clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  is the reset, synchronous and active-high.
REQ-006 req_valid  input  NUM_REQ  indicates that requester i presents an operand.
REQ-007 req_data  input  NUM_REQ*8  carries the 8-bit fraction operand |t| of each requester.
REQ-008 req_sign  input  NUM_REQ  carries the operand sign of each requester (1 = negative).
REQ-009 req_ready  output  NUM_REQ  is the one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-010 k_data  output  8  drives kernel iData.
REQ-011 k_sign  output  1  drives kernel iSign.
REQ-012 k_result  input  10  is kernel oData, in {2,8} format.
REQ-013 res_valid  output  1  indicates that the FIFO head result is available.
REQ-014 res_ready  input  1  is the consumer accept for the head result.
REQ-015 res_data  output  10  is the head result value.
REQ-016 res_id  output  clog2(NUM_REQ)  is the requester index of the head result.

Function
REQ-017 Arbitration SHALL be round-robin: search starts at rr_ptr and wraps; after a grant to i, rr_ptr becomes (i+1) mod NUM_REQ; rr_ptr is unchanged when there is no grant.
REQ-018 At most one req_ready bit SHALL be high per cycle; req_ready SHALL be combinational from req_valid, rr_ptr and credit, and SHALL be 0 for non-valid requesters.
REQ-019 Credit: a grant SHALL occur only if inflight + fifo_count < DEPTH; a same-cycle pop SHALL NOT add credit.
REQ-020 In a grant cycle, k_data/k_sign SHALL equal the granted requester's operand; otherwise they SHALL be 0.
REQ-021 Tag pipeline: a LAT-stage shift register of {valid, id}; stage LAT SHALL be aligned with the k_result produced by that operand.
REQ-022 When stage LAT is valid, {id, k_result} SHALL be written to the FIFO at the end of that cycle; invalid stages SHALL be ignored.
REQ-023 Latency: an operand accepted in cycle T SHALL have its result visible with res_valid=1 in cycle T+LAT+1 if the FIFO was empty.
REQ-024 FIFO: first-word fall-through, in-order; res_valid = (fifo_count != 0); pop when res_valid && res_ready.
REQ-025 A simultaneous push and pop SHALL leave fifo_count unchanged, and a push into an empty FIFO SHALL become visible the next cycle.
REQ-026 Overflow SHALL be impossible by construction of the credit rule; reading from an empty FIFO SHALL NOT change state.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH.
REQ-028 The inflight count SHALL be incremented on grant and decremented on a valid stage LAT, with both in the same cycle leaving it unchanged.
REQ-029 Full throughput of one grant per cycle SHALL be sustained while res_ready=1.

Reset
REQ-030 On rst, the block SHALL clear: rr_ptr=0, all tag stages invalid, inflight=0, FIFO empty, res_valid=0, req_ready=0, k_data=0, k_sign=0.
REQ-031 A reset mid-operation SHALL discard in-flight and buffered results; kernel outputs emerging after reset SHALL be ignored because their tags are invalid.

Configuration
REQ-032 With KSCHED_PERF_EN defined, the block SHALL add output perf_issue_cnt[15:0], which counts grants, saturates at 16'hFFFF and is cleared by rst.
REQ-033 With KSCHED_PERF_EN undefined, the port and counter SHALL be absent and the rest of the behaviour SHALL be identical.

Verification
REQ-034 A single request from requester 2 (data 8'h00, sign 0) accepted in cycle T -> res_valid in cycle T+6 with res_data=10'h100 and res_id=2.
REQ-035 All four requesters continuously valid with res_ready=1 -> grants 0,1,2,3,0,... one per cycle, and res_id follows the same sequence.
REQ-036 res_ready=0 while all requesters are valid -> exactly 8 grants, then req_ready=0; the first pop restores exactly one grant.
REQ-037 Random operands and random res_ready -> every result equals a standalone kernel model for that operand, in order, with no loss or duplication.
REQ-038 rst asserted with 3 operations in flight and 2 buffered -> no res_valid for LAT+1 cycles after reset, and the next request returns the correct result.
REQ-039 With KSCHED_PERF_EN defined, 10 accepted requests -> perf_issue_cnt=10; a preload near 16'hFFFF saturates without wrapping.
